bf_run_decoder: RTL and testbench
=================================

# bf_run_decoder

Streaming decoder for the Brainfuck core's instruction fetch path. It accepts one program byte per cycle over a valid/ready handshake and drops non-command bytes. It folds runs of identical `>` `<` `+` `-` into a single record carrying a repeat count, and emits one-hot decoded records to the execute stage. It also checks bracket nesting and raises a sticky error on malformed programs.

## Interface
- `CNT_W`, default 8: repeat-count width; maximum run length is 2^CNT_W−1.
- `DEPTH_W`, default 6: bracket-depth counter width; maximum nesting is 2^DEPTH_W−1.
- `CLK` in 1: the only clock. One clock; reset is asynchronous and active-high.
- `RST` in 1: asynchronous, active-high reset.
- `IN_VALID` in 1: `IN_OPCODE` and `IN_LAST` are valid.
- `IN_READY` out 1: decoder accepts a byte this cycle.
- `IN_OPCODE` in 8: program byte (ASCII).
- `IN_LAST` in 1: this byte is the final byte of the program.
- `OUT_VALID` out 1: an output record is held.
- `OUT_READY` in 1: downstream accepts the record.
- `OUT_DECODED` out 8: one-hot command. Bit 0 `>`, bit 1 `<`, bit 2 `+`, bit 3 `-`, bit 4 `.`, bit 5 `,`, bit 6 `[`, bit 7 `]`.
- `OUT_COUNT` out CNT_W: repeat count, 1..2^CNT_W−1. It is 0 only on an empty end record.
- `OUT_LAST` out 1: final record of the program.
- `ERR` out 1: sticky bracket error.

## Operation
- Command bytes: 0x3E `>`, 0x3C `<`, 0x2B `+`, 0x2D `-`, 0x2E `.`, 0x2C `,`, 0x5B `[`, 0x5D `]`. All other bytes are accepted and discarded.
- State is an accumulator (`acc_op`, `acc_cnt`, `acc_full`), an output register, and `flush_pend`.
- An accepted command merges into the accumulator when all of the following hold: it is foldable (bits 0–3), it equals `acc_op`, and `acc_cnt` < 2^CNT_W−1. A merge does `acc_cnt`+1.
- Any other accepted command closes the accumulator:
  - the old accumulator contents move to the output register (if `acc_full`);
  - the new command loads the accumulator with count 1.
- `.` `,` `[` `]` never merge. Each produces its own record.
- Count saturation: the next identical op starts a new record, so 300×`+` with CNT_W=8 produces records 255 and 45.
- End of program:
  - An accepted byte with `IN_LAST`=1 is processed as above, then sets `flush_pend`.
  - When the output register is free, the accumulator moves out with `OUT_LAST`=1 and `flush_pend` clears.
  - If the accumulator is empty, an end record is emitted instead: DECODED=0, COUNT=0, LAST=1.
- Bracket check, applied on the accepted byte:
  - `[` at maximum depth → ERR; depth is unchanged.
  - `]` at depth 0 → ERR.
  - At `IN_LAST` acceptance, depth≠0 after the byte → ERR.
  - Depth resets to 0 after `IN_LAST`.
  - ERR clears only on RST. Records still flow when ERR=1.

## Timing
- `IN_READY` = !`flush_pend` && (!`OUT_VALID` || `OUT_READY`). This is combinational from `OUT_READY` and state only, never from `IN_VALID`.
- Transfers occur on the rising `CLK` edge where valid && ready.
- A command's record appears (`OUT_VALID`=1) the cycle after the edge that accepts the next non-merging command, or one cycle after the `IN_LAST` edge at the earliest.
- Simultaneous output drain and input closing the accumulator on the same edge: the output register reloads, and `OUT_VALID` stays 1.
- `OUT_*` are held stable while `OUT_VALID` && !`OUT_READY`.
- Reset values:
  - `OUT_VALID`, `OUT_DECODED`, `OUT_COUNT`, `OUT_LAST`, `ERR` all 0;
  - accumulator empty, depth 0, `flush_pend` 0;
  - hence `IN_READY`=1.
- Reset mid-program discards the accumulator and any held record; no partial record is emitted.

## Configuration
- `BF_FOLD_EN` defined: run folding as above.
- `BF_FOLD_EN` undefined: no merging. Every command emits its own record with COUNT=1. Handshake, latency, end record, and bracket checking are unchanged.

## Structure
- Shared package `bf_pkg`:
  - the eight opcode byte constants;
  - one-hot bit index constants (`BF_OP_RIGHT` … `BF_OP_LOOPE`);
  - the decoded width of 8.
- Sub-module `bf_opcode_lookup`: combinational byte → {one-hot[7:0], `is_cmd`, `is_fold`}. Used once here; shared with the core's execute stage.

## Test plan
- Stream `+++>>-` with `IN_LAST` on `-`, `OUT_READY`=1 → records (`+`,3), (`>`,2), (`-`,1,LAST). ERR=0.
- 300×`+` then `IN_LAST` (CNT_W=8) → (`+`,255), (`+`,45,LAST).
- `a+b\n+` with `IN_LAST` on the final `+` → single record (`+`,2,LAST); comment bytes are dropped. Input `xyz` with LAST → end record DECODED=0, COUNT=0, LAST=1.
- Hold `OUT_READY`=0 for 5 cycles mid-stream → `IN_READY`=0 while `OUT_VALID`; output stable; no bytes lost.
- `]` first → ERR=1 on the next cycle and remains set. `[[` then LAST → ERR=1. `[-]` → ERR=0.
- Assert RST during a `+` run after 4 bytes → all outputs 0, `IN_READY`=1. Then `-` with LAST → (`-`,1,LAST) only.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck instruction path.
// Holds the ASCII values of the eight command bytes and the bit position
// of each command in the one-hot decoded vector. It also defines the
// decoded width and the mask of commands whose runs can be folded.
package bf_pkg;

  localparam int BF_DEC_W = 8;

  typedef logic [BF_DEC_W-1:0] bf_dec_t;

  // ASCII command bytes
  localparam logic [7:0] BF_CHR_RIGHT = 8'h3E;  // >
  localparam logic [7:0] BF_CHR_LEFT  = 8'h3C;  // <
  localparam logic [7:0] BF_CHR_INC   = 8'h2B;  // +
  localparam logic [7:0] BF_CHR_DEC   = 8'h2D;  // -
  localparam logic [7:0] BF_CHR_OUT   = 8'h2E;  // .
  localparam logic [7:0] BF_CHR_IN    = 8'h2C;  // ,
  localparam logic [7:0] BF_CHR_LOOPS = 8'h5B;  // [
  localparam logic [7:0] BF_CHR_LOOPE = 8'h5D;  // ]

  // One-hot bit positions in the decoded vector
  localparam int BF_OP_RIGHT = 0;
  localparam int BF_OP_LEFT  = 1;
  localparam int BF_OP_INC   = 2;
  localparam int BF_OP_DEC   = 3;
  localparam int BF_OP_OUT   = 4;
  localparam int BF_OP_IN    = 5;
  localparam int BF_OP_LOOPS = 6;
  localparam int BF_OP_LOOPE = 7;

  // Only pointer moves and cell increments/decrements fold into runs
  localparam bf_dec_t BF_FOLD_MASK = 8'h0F;

endpackage

// File: rtl/bf_opcode_lookup.sv
// Combinational program-byte classifier, shared with the execute stage.
// Ports:
//   opcode  in  8  program byte (ASCII)
//   decoded out 8  one-hot command, all zero for non-command bytes
//   is_cmd  out 1  byte is one of the eight commands
//   is_fold out 1  byte is a command whose runs can be folded (> < + -)
module bf_opcode_lookup
  import bf_pkg::*;
(
  input  logic [7:0] opcode,
  output bf_dec_t    decoded,
  output logic       is_cmd,
  output logic       is_fold
);

  // Map each command byte to its one-hot slot
  always_comb begin
    decoded = {BF_DEC_W{1'b0}};
    case (opcode)
      BF_CHR_RIGHT: decoded[BF_OP_RIGHT] = 1'b1;
      BF_CHR_LEFT:  decoded[BF_OP_LEFT]  = 1'b1;
      BF_CHR_INC:   decoded[BF_OP_INC]   = 1'b1;
      BF_CHR_DEC:   decoded[BF_OP_DEC]   = 1'b1;
      BF_CHR_OUT:   decoded[BF_OP_OUT]   = 1'b1;
      BF_CHR_IN:    decoded[BF_OP_IN]    = 1'b1;
      BF_CHR_LOOPS: decoded[BF_OP_LOOPS] = 1'b1;
      BF_CHR_LOOPE: decoded[BF_OP_LOOPE] = 1'b1;
      default:      decoded = {BF_DEC_W{1'b0}};
    endcase
  end

  assign is_cmd  = |decoded;
  assign is_fold = |(decoded & BF_FOLD_MASK);

endmodule

// File: rtl/bf_run_decoder.sv
// Streaming run-length decoder for the Brainfuck fetch path.
// It accepts one program byte per cycle and drops non-command bytes. Runs
// of identical > < + - fold into one record carrying a repeat count.
// Bracket nesting is checked, and a sticky error is raised on bad programs.
// Build option: define BF_FOLD_EN to enable run folding. Without it, every
// command produces its own record with count 1.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   IN_VALID/IN_READY   input handshake; IN_OPCODE byte, IN_LAST end of program
//   OUT_VALID/OUT_READY output handshake
//   OUT_DECODED         one-hot command (all zero on an empty end record)
//   OUT_COUNT           repeat count (zero only on an empty end record)
//   OUT_LAST            final record of the program
//   ERR                 sticky bracket-nesting error
module bf_run_decoder
  import bf_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEPTH_W = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [7:0]          IN_OPCODE,
  input  logic                IN_LAST,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [BF_DEC_W-1:0] OUT_DECODED,
  output logic [CNT_W-1:0]    OUT_COUNT,
  output logic                OUT_LAST,
  output logic                ERR
);

`ifdef BF_FOLD_EN
  localparam logic FOLD_EN = 1'b1;
`else
  localparam logic FOLD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = {DEPTH_W{1'b1}};

  bf_dec_t            dec_s;
  logic               is_cmd_s;
  logic               is_fold_s;
  logic               out_free_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               merge_s;
  logic               close_s;
  logic               flush_go_s;
  logic [DEPTH_W-1:0] depth_nxt_s;
  logic               err_set_s;

  bf_dec_t            acc_op_r;
  logic [CNT_W-1:0]   acc_cnt_r;
  logic               acc_full_r;
  logic               out_valid_r;
  bf_dec_t            out_dec_r;
  logic [CNT_W-1:0]   out_cnt_r;
  logic               out_last_r;
  logic               flush_pend_r;
  logic [DEPTH_W-1:0] depth_r;
  logic               err_r;

  bf_opcode_lookup u_lookup (
    .opcode  (IN_OPCODE),
    .decoded (dec_s),
    .is_cmd  (is_cmd_s),
    .is_fold (is_fold_s)
  );

  // The output register can take a new record when empty or draining this edge
  assign out_free_s = !out_valid_r || OUT_READY;
  // Input stalls while an end-of-program flush waits for the output register
  assign in_ready_s = !flush_pend_r && out_free_s;
  assign accept_s   = IN_VALID && in_ready_s;

  // Fold only into a live accumulator of the same foldable op with headroom
  assign merge_s    = FOLD_EN && accept_s && is_fold_s && acc_full_r &&
                      (dec_s == acc_op_r) && (acc_cnt_r != CNT_MAX);
  assign close_s    = accept_s && is_cmd_s && !merge_s;
  // Input is blocked while flush is pending, so a flush never races a close
  assign flush_go_s = flush_pend_r && out_free_s;

  // Bracket depth and error detection for the byte accepted this cycle
  always_comb begin
    depth_nxt_s = depth_r;
    err_set_s   = 1'b0;
    if (accept_s) begin
      if (dec_s[BF_OP_LOOPS]) begin
        if (depth_r == DEPTH_MAX) begin
          err_set_s = 1'b1;  // overflow: depth is held, not wrapped
        end else begin
          depth_nxt_s = depth_r + DEPTH_ONE;
        end
      end else if (dec_s[BF_OP_LOOPE]) begin
        if (depth_r == DEPTH_ZERO) begin
          err_set_s = 1'b1;
        end else begin
          depth_nxt_s = depth_r - DEPTH_ONE;
        end
      end else begin
        depth_nxt_s = depth_r;
      end
      if (IN_LAST) begin
        if (depth_nxt_s != DEPTH_ZERO) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = err_set_s;
        end
        depth_nxt_s = DEPTH_ZERO;  // each program starts at depth zero
      end else begin
        depth_nxt_s = depth_nxt_s;
      end
    end else begin
      depth_nxt_s = depth_r;
      err_set_s   = 1'b0;
    end
  end

  // Bracket depth counter and sticky error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      depth_r <= DEPTH_ZERO;
      err_r   <= 1'b0;
    end else begin
      depth_r <= depth_nxt_s;
      err_r   <= err_r | err_set_s;
    end
  end

  // Run accumulator: grow on merge, reload on close, empty on flush
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_op_r   <= {BF_DEC_W{1'b0}};
      acc_cnt_r  <= CNT_ZERO;
      acc_full_r <= 1'b0;
    end else if (flush_go_s) begin
      acc_op_r   <= {BF_DEC_W{1'b0}};
      acc_cnt_r  <= CNT_ZERO;
      acc_full_r <= 1'b0;
    end else if (merge_s) begin
      acc_cnt_r  <= acc_cnt_r + CNT_ONE;
    end else if (close_s) begin
      acc_op_r   <= dec_s;
      acc_cnt_r  <= CNT_ONE;
      acc_full_r <= 1'b1;
    end
  end

  // End-of-program flag: set by the last byte, cleared when the final record leaves
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flush_pend_r <= 1'b0;
    end else if (flush_go_s) begin
      flush_pend_r <= 1'b0;
    end else if (accept_s && IN_LAST) begin
      flush_pend_r <= 1'b1;
    end
  end

  // Output record register; a reload on the drain edge keeps OUT_VALID high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_r <= 1'b0;
      out_dec_r   <= {BF_DEC_W{1'b0}};
      out_cnt_r   <= CNT_ZERO;
      out_last_r  <= 1'b0;
    end else if (flush_go_s) begin
      // An empty accumulator yields the all-zero end record
      out_valid_r <= 1'b1;
      out_dec_r   <= acc_full_r ? acc_op_r : {BF_DEC_W{1'b0}};
      out_cnt_r   <= acc_full_r ? acc_cnt_r : CNT_ZERO;
      out_last_r  <= 1'b1;
    end else if (close_s && acc_full_r) begin
      out_valid_r <= 1'b1;
      out_dec_r   <= acc_op_r;
      out_cnt_r   <= acc_cnt_r;
      out_last_r  <= 1'b0;
    end else if (OUT_READY) begin
      out_valid_r <= 1'b0;
    end
  end

  assign IN_READY    = in_ready_s;
  assign OUT_VALID   = out_valid_r;
  assign OUT_DECODED = out_dec_r;
  assign OUT_COUNT   = out_cnt_r;
  assign OUT_LAST    = out_last_r;
  assign ERR         = err_r;

endmodule

// File: tb/tb_bf_run_decoder.sv
// Self-checking bench for bf_run_decoder. It drives directed and random
// programs and compares the records against a run-list reference model.
module tb_bf_run_decoder;

  localparam int CW   = 8;
  localparam int DW   = 6;
  localparam int CMAX = (1 << CW) - 1;
  localparam int DMAX = (1 << DW) - 1;
`ifdef BF_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif

  typedef logic [7:0]    byte_q_t[$];
  typedef logic [CW+8:0] rec_t;  // {decoded, count, last}

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [7:0]    IN_OPCODE;
  logic          IN_LAST;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [7:0]    OUT_DECODED;
  logic [CW-1:0] OUT_COUNT;
  logic          OUT_LAST;
  logic          ERR;

  bf_run_decoder #(.CNT_W(CW), .DEPTH_W(DW)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OPCODE(IN_OPCODE), .IN_LAST(IN_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DECODED(OUT_DECODED),
    .OUT_COUNT(OUT_COUNT), .OUT_LAST(OUT_LAST), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_errors = 0;
  int   bp_mode  = 0;   // 0 always ready, 1 random, 2 held low
  int   gap_en   = 0;
  logic err_model = 1'b0;
  rec_t exp_q[$];
  rec_t obs_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rec_t cur_rec();
    return {OUT_DECODED, OUT_COUNT, OUT_LAST};
  endfunction

  // Index of a command in the one-hot order, or -1 for a comment byte
  function automatic int cmd_idx(input logic [7:0] b);
    string s = "><+-.,[]";
    for (int i = 0; i < s.len(); i++) if (s[i] == b) return i;
    return -1;
  endfunction

  // Reference model: list of (op, run length) and bracket depth walk
  function automatic void build_expected(input byte_q_t prog);
    int ops[$];
    int cnts[$];
    int depth = 0;
    int idx;
    exp_q.delete();
    foreach (prog[k]) begin
      idx = cmd_idx(prog[k]);
      if (idx >= 0) begin
        if (FOLD && idx < 4 && ops.size() > 0 && ops[ops.size()-1] == idx &&
            cnts[cnts.size()-1] < CMAX)
          cnts[cnts.size()-1] = cnts[cnts.size()-1] + 1;
        else begin
          ops.push_back(idx);
          cnts.push_back(1);
        end
        if (idx == 6) begin
          if (depth == DMAX) err_model = 1'b1; else depth++;
        end
        if (idx == 7) begin
          if (depth == 0) err_model = 1'b1; else depth--;
        end
      end
    end
    if (depth != 0) err_model = 1'b1;
    foreach (ops[k])
      exp_q.push_back({8'(1 << ops[k]), CW'(cnts[k]), (k == ops.size() - 1)});
    if (ops.size() == 0) exp_q.push_back(rec_t'(1));
  endfunction

  function automatic byte_q_t from_str(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic byte_q_t repeat_byte(input logic [7:0] b, input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(b);
    return q;
  endfunction

  // Downstream ready generator
  initial begin
    OUT_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (bp_mode)
        0:       OUT_READY = 1'b1;
        1:       OUT_READY = 1'($urandom_range(0, 1));
        default: OUT_READY = 1'b0;
      endcase
    end
  end

  // Output monitor: collects transfers, checks hold stability and input stall
  initial begin
    logic hold;
    rec_t prev;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", OUT_VALID, 1);
          check("hold_data", cur_rec(), prev);
        end
        if (OUT_VALID && !OUT_READY) check("in_ready_stall", IN_READY, 0);
        if (OUT_VALID && OUT_READY) obs_q.push_back(cur_rec());
        hold = OUT_VALID && !OUT_READY;
        prev = cur_rec();
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    IN_VALID  = 1'b1;
    IN_OPCODE = b;
    IN_LAST   = last;
    @(negedge CLK);
    while (!IN_READY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) check("in_ready_timeout", n, 0);
    @(posedge CLK);
    #1;
    // Idle-cycle bait: a command byte with VALID low must be ignored
    IN_VALID  = 1'b0;
    IN_OPCODE = 8'h2B;
    IN_LAST   = 1'($urandom_range(0, 1));
    if (gap_en != 0) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic run_program(input string tag, input byte_q_t prog);
    int n = 0;
    build_expected(prog);
    obs_q.delete();
    foreach (prog[k]) send_byte(prog[k], (k == prog.size() - 1));
    while (obs_q.size() < exp_q.size() && n < 2000) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check({tag, "_nrec"}, obs_q.size(), exp_q.size());
    foreach (exp_q[k]) if (k < obs_q.size()) check({tag, "_rec"}, obs_q[k], exp_q[k]);
    repeat (4) @(posedge CLK);
    #1;
    if (bp_mode != 2) check({tag, "_idle"}, OUT_VALID, 0);
    check({tag, "_err"}, ERR, err_model);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ov"}, OUT_VALID, 0);
    check({tag, "_od"}, OUT_DECODED, 0);
    check({tag, "_oc"}, OUT_COUNT, 0);
    check({tag, "_ol"}, OUT_LAST, 0);
    check({tag, "_err"}, ERR, 0);
    check({tag, "_ir"}, IN_READY, 1);
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    RST      = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_zero_outputs("rst");
    RST = 1'b0;
    err_model = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    byte_q_t q;
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN_OPCODE = 8'h00;
    IN_LAST = 1'b0;
    do_reset();

    run_program("basic", from_str("+++>>-"));
    run_program("sat300", repeat_byte(8'h2B, 300));
    run_program("comment", from_str("a+b\n+"));
    run_program("endrec", from_str("xyz"));
    run_program("close_first", from_str("]"));
    run_program("err_sticky", from_str("+.,"));

    do_reset();
    run_program("open2", from_str("[["));
    do_reset();
    run_program("loop_ok", from_str("[-]"));

    // Downstream stalled for five cycles in the middle of a stream
    fork
      run_program("hold", from_str("+-+-.,>><<[+]"));
      begin
        repeat (3) @(posedge CLK);
        bp_mode = 2;
        repeat (5) @(posedge CLK);
        bp_mode = 0;
      end
    join

    // Nesting limit: full depth is legal, one more open raises ERR
    do_reset();
    q = repeat_byte(8'h5B, DMAX);
    foreach (q[k]) if (k >= 0) begin end
    for (int i = 0; i < DMAX; i++) q.push_back(8'h5D);
    run_program("depth_max", q);
    q = repeat_byte(8'h5B, DMAX + 1);
    for (int i = 0; i < DMAX; i++) q.push_back(8'h5D);
    run_program("depth_ovf", q);

    // Reset in the middle of a run discards everything held
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h2B, 1'b0);
    RST = 1'b1;
    #2;
    check_zero_outputs("midrst");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    err_model = 1'b0;
    @(posedge CLK);
    #1;
    check_zero_outputs("postrst");
    run_program("after_rst", from_str("-"));

    // Random run-structured programs under random backpressure and gaps
    for (int p = 0; p < 14; p++) begin
      byte_q_t rq;
      string pool = "><+-.,[]a\n";
      int nruns = $urandom_range(1, 8);
      bp_mode = p % 2;
      gap_en  = (p % 3 == 0) ? 1 : 0;
      for (int r = 0; r < nruns; r++) begin
        logic [7:0] b = pool[$urandom_range(0, pool.len() - 1)];
        int rep = $urandom_range(1, 6);
        for (int j = 0; j < rep; j++) rq.push_back(b);
      end
      run_program("rnd", rq);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
